// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute sequencer for the 16-bit CPU
module cpu_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             run,
  input  logic [15:0]      ir,
  input  logic             mem_ready,
  input  logic             alu_lsb,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             alu_en,
  output logic             rf_we,
  output logic             rf_wsel,
  output logic             cond_flag,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, MEM, BRANCH, HALT} state_t;
  state_t cur, nxt;
  logic [4:0] op;
  logic is_st, is_ld, is_cmp, retire, unused_ir;
  assign unused_ir = ^ir[15:5];
  assign is_st = op == 5'd18;
  assign is_ld = op == 5'd19;
  assign is_cmp = op == 5'd14 || op == 5'd15 || op == 5'd16;
  assign retire = cur == WB || cur == BRANCH || (cur == MEM && is_st && mem_ready);
  // state, latched opcode, compare flag and retire counter
  always_ff @(posedge CLK) begin
    if (reset) begin
      cur <= IDLE;
      op <= '0;
      cond_flag <= 1'b0;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) op <= ir[4:0];
      if (cur == WB && is_cmp) cond_flag <= alu_lsb;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end
  // next-state: retiring states share one exit, the rest wait on run/mem_ready or decode ir
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    nxt = run ? FETCH : IDLE;
      FETCH:   nxt = mem_ready ? DECODE : FETCH;
      DECODE:  nxt = ir[4:0] <= 5'd16 ? EXEC : ir[4:0] == 5'd17 ? BRANCH :
                     ir[4:0] <= 5'd19 ? MEM : HALT;
      EXEC:    nxt = WB;
      MEM:     nxt = !mem_ready ? MEM : is_st ? (run ? FETCH : IDLE) : WB;
      WB:      nxt = run ? FETCH : IDLE;
      BRANCH:  nxt = run ? FETCH : IDLE;
      default: nxt = HALT;
    endcase
  end
  assign mem_rd       = cur == FETCH || (cur == MEM && !is_st);
  assign mem_wr       = cur == MEM && is_st;
  assign mem_addr_sel = cur == MEM;
  assign ir_load      = cur == FETCH && mem_ready;
  assign pc_inc       = cur == FETCH && mem_ready;
  assign pc_load      = cur == BRANCH && cond_flag;
  assign alu_en       = cur == EXEC;
  assign rf_we        = cur == WB;
  assign rf_wsel      = cur == WB && is_ld;
  assign halted       = cur == HALT;
  assign state        = cur;
endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control unit for the 16-bit CPU. Sequences instruction fetch, decode, ALU execute, register writeback, load/store and branch. Drives the IR, PC, register file, ALU and memory-port control strobes around the existing instruction decoder, and holds the comparison flag used by BR.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- ir  in  16  current instruction register contents; ir[4:0] is the opcode field.
- mem_ready  in  1  memory handshake; request completes in any cycle it is high while mem_rd or mem_wr is high.
- alu_lsb  in  1  bit 0 of the ALU result, sampled for compare instructions.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request (STW).
- mem_addr_sel  out  1  0 = address from PC, 1 = address from rA value.
- ir_load  out  1  load IR from memory read data.
- pc_inc  out  1  PC <= PC+1.
- pc_load  out  1  PC <= rA value (taken branch).
- alu_en  out  1  ALU operands/op valid; ALU result register captures.
- rf_we  out  1  register file write enable for rOut.
- rf_wsel  out  1  0 = write ALU result, 1 = write memory read data.
- cond_flag  out  1  last compare result.
- halted  out  1  illegal opcode trapped.
- state  out  3  current state encoding, for debug.
- instr_count  out  CNT_W  instructions retired since reset.

## Operation
- Opcodes: 0–15 are ALU/compare ops, with 7–13 as immediates. 14 = GT, 15 = LT, 16 = EQ, 17 = BR, 18 = STW, 19 = LDW. Values 20–31 are illegal.
- States, with encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, WB = 4, MEM = 5, BRANCH = 6, HALT = 7.
- IDLE: all strobes 0. Goes to FETCH when run = 1.
- FETCH: mem_rd = 1, mem_addr_sel = 0. In the cycle mem_ready = 1, ir_load and pc_inc pulse for that single cycle, then go to DECODE. Otherwise stay.
- DECODE: one cycle, no strobes. Opcode selects the next state:
  - 0–16 → EXEC.
  - 17 → BRANCH.
  - 18 or 19 → MEM.
  - 20–31 → HALT.
- The opcode and load/store kind are latched in DECODE. Later states use the latched copy, not ir.
- EXEC: alu_en = 1 for one cycle, then go to WB.
- WB: rf_we = 1 for one cycle, with rf_wsel = 1 when the latched op is LDW, else 0. For GT/LT/EQ, cond_flag <= alu_lsb at this edge. The instruction retires here.
- MEM: mem_addr_sel = 1, with mem_wr = 1 for STW or mem_rd = 1 for LDW. Hold until mem_ready. Then LDW goes to WB; STW retires directly.
- BRANCH: pc_load = cond_flag for one cycle, then retire. cond_flag itself is not modified.
- Retire: instr_count increments by 1, wrapping at 2^CNT_W. Next state is FETCH if run = 1, else IDLE.
- HALT: halted = 1, all strobes 0. Exited only by reset. run is ignored; instr_count does not increment.
- Outputs are combinational from state, latched opcode and mem_ready. cond_flag, instr_count and state are registered.

## Timing
- Reset, applied in any state including mid-handshake: next state IDLE; cond_flag = 0, instr_count = 0, halted = 0. All strobes are 0 in the cycle after the reset edge. An in-flight memory request is abandoned.
- Zero-wait memory (mem_ready high on the first request cycle) gives these minimum latencies, FETCH entry to retire:
  - ALU/compare: 4 cycles.
  - LDW: 4 cycles.
  - STW: 3 cycles.
  - BR: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- Back-to-back instructions: FETCH is entered on the cycle after retire, with no bubble.
- run = 0 mid-instruction: the current instruction completes, then the FSM goes to IDLE. run = 1 in IDLE starts FETCH on the next cycle.
- mem_ready high outside FETCH/MEM is ignored.
- Never assert mem_rd and mem_wr together. Never assert pc_inc and pc_load together.

## Test plan
- ADD (ir = 0x0000), run = 1, mem_ready tied 1: states go 1, 2, 3, 4, 1. There is one pulse each of ir_load, pc_inc, alu_en and rf_we with rf_wsel = 0. instr_count = 1 after 4 cycles.
- FETCH with mem_ready low for 3 cycles: mem_rd is held for 4 cycles. ir_load/pc_inc pulse only in the 4th cycle.
- EQ (opcode 16) with alu_lsb = 1, then BR (opcode 17): cond_flag = 1 after WB, and pc_load pulses once in BRANCH. Repeat with alu_lsb = 0: no pc_load.
- LDW (19) then STW (18), with mem_ready delayed 2 cycles in MEM:
  - LDW: mem_rd with mem_addr_sel = 1 for 3 cycles, then WB with rf_wsel = 1.
  - STW: mem_wr for 3 cycles and no rf_we. instr_count increments by 2.
- Illegal opcode 25: DECODE goes to HALT, halted = 1, and the FSM stays in HALT while run = 1. Reset gives IDLE with halted = 0 and instr_count = 0.
- Reset asserted during a MEM wait: the next cycle is IDLE with all strobes 0. Also drop run during EXEC: WB completes, then IDLE.
